// File: rtl/reg_scan_if.sv
// reg_scan port bundle: CPU debug read bus, display read port,
// scan control and change-mask status.
interface reg_scan_if;
  logic        scan_en;
  logic [4:0]  regadd;
  logic [3:0]  regdata;
  logic [4:0]  rd_addr;
  logic [3:0]  rd_data;
  logic        frame_done;
  logic        clr_chg;
  logic [31:0] chg_mask;

  modport master (
    output scan_en, regdata, rd_addr, clr_chg,
    input  regadd, rd_data, frame_done, chg_mask
  );

  modport slave (
    input  scan_en, regdata, rd_addr, clr_chg,
    output regadd, rd_data, frame_done, chg_mask
  );
endinterface

// File: rtl/reg_scan.sv
// Register-file scanner: walks regadd 0..31, snapshots regdata per entry.
// Optional change tracking is enabled by defining REG_SCAN_CHANGE_EN.
module reg_scan #(
  parameter int SETTLE = 2
) (
  input logic     clk100m,
  input logic     rst,
  reg_scan_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [4:0]  addr;
  logic [3:0]  mem [32];
  logic        done;
  logic [3:0]  rdq;
  logic [31:0] chg;
  logic        cap;

  assign cap = (state == ST_CAPTURE);

  // rd_data samples mem before any same-edge capture write lands
  always_ff @(posedge clk100m) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      addr  <= '0;
      done  <= 1'b0;
      rdq   <= '0;
      for (int i = 0; i < 32; i++)
        mem[i] <= '0;
    end else begin
      done <= 1'b0;
      rdq  <= mem[bus.rd_addr];
      unique case (state)
        ST_IDLE: begin
          addr <= '0;
          cnt  <= '0;
          if (bus.scan_en)
            state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == LAST)
            state <= ST_CAPTURE;
          else
            cnt <= cnt + 4'd1;
        end
        ST_CAPTURE: begin
          mem[addr] <= bus.regdata;
          cnt       <= '0;
          if (addr == 5'd31) begin
            done  <= 1'b1;
            addr  <= '0;
            state <= bus.scan_en ? ST_SETTLE
                                 : ST_IDLE;
          end else begin
            addr  <= addr + 5'd1;
            state <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef REG_SCAN_CHANGE_EN
  logic [31:0] set_v;

  always_comb begin
    set_v = '0;
    if (cap && (bus.regdata != mem[addr]))
      set_v[addr] = 1'b1;
  end

  // a bit being set on the clearing edge survives the clear
  always_ff @(posedge clk100m) begin
    if (!rst)
      chg <= '0;
    else if (bus.clr_chg)
      chg <= set_v;
    else
      chg <= chg | set_v;
  end
`else
  logic unused_chg;
  assign unused_chg = bus.clr_chg ^ cap;
  assign chg = '0;
`endif

  assign bus.regadd     = addr;
  assign bus.rd_data    = rdq;
  assign bus.frame_done = done;
  assign bus.chg_mask   = chg;

endmodule

// File: doc/reg_scan.md
REG_SCAN -- requirements
Module: reg_scan

Interface
REQ-001 SHALL have parameter SETTLE, default 2: cycles waited after each regadd change before sampling regdata; legal range 1..15.
REQ-002 SHALL have clk100m  input  1  system clock, all logic on its rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have scan_en  input  1  level; 1 = keep scanning frames.
REQ-005 SHALL have regadd  output  5  register-file debug address driven to the CPU.
REQ-006 SHALL have regdata  input  4  CPU debug read data for regadd.
REQ-007 SHALL have rd_addr  input  5  display-side read address.
REQ-008 SHALL have rd_data  output  4  snapshot entry at rd_addr, registered.
REQ-009 SHALL have frame_done  output  1  one-cycle pulse when entry 31 is captured.
REQ-010 SHALL have clr_chg  input  1  pulse; clears change mask.
REQ-011 SHALL have chg_mask  output  32  bit i = entry i changed since last clear.

Function
REQ-012 SHALL hold a 32 x 4-bit snapshot buffer written only by the scan FSM.
REQ-013 SHALL implement FSM states IDLE, SETTLE, CAPTURE.
REQ-014 IDLE: regadd = 0; scan_en = 1 -> SETTLE with settle counter = 0; else stay.
REQ-015 SETTLE: counter increments each cycle; counter == SETTLE-1 -> CAPTURE.
REQ-016 CAPTURE (exactly one cycle): buffer[regadd] <= regdata.
REQ-017 CAPTURE with regadd < 31: regadd increments, counter cleared, -> SETTLE.
REQ-018 CAPTURE with regadd == 31: frame_done = 1 the next cycle, regadd wraps to 0, -> SETTLE if scan_en = 1, else IDLE.
REQ-019 Per-entry period SHALL be SETTLE+1 cycles; frame period 32*(SETTLE+1) cycles (96 at default).
REQ-020 scan_en falling mid-frame SHALL NOT abort; current frame completes, then IDLE.
REQ-021 regadd SHALL change only on the cycle after CAPTURE; it is stable during SETTLE and CAPTURE.
REQ-022 rd_data SHALL equal buffer[rd_addr] one cycle after rd_addr is presented.
REQ-023 Simultaneous capture and read of the same entry SHALL return the pre-write value, with the new value on the following read.
REQ-024 frame_done SHALL be high for exactly one cycle per completed frame.

Reset
REQ-025 rst = 0 at a clock edge SHALL force IDLE, regadd = 0, counter = 0, frame_done = 0, rd_data = 0, chg_mask = 0, all buffer entries = 0.
REQ-026 Reset mid-frame SHALL discard the partial frame; no frame_done pulse is produced for it.
REQ-027 After rst returns to 1 with scan_en = 1, first capture SHALL occur SETTLE+1 cycles later, at entry 0.

Configuration
REQ-028 Macro REG_SCAN_CHANGE_EN SHALL gate change tracking.
REQ-029 Defined: on CAPTURE, if regdata != buffer[regadd], chg_mask[regadd] <= 1; clr_chg clears all bits; same-cycle set and clear -> set wins for that bit, the others clear.
REQ-030 Undefined: chg_mask tied to 0, clr_chg ignored, no comparison logic synthesised; ports unchanged.

Verification
REQ-031 Reset released, scan_en = 1, regdata = regadd[3:0] model -> after 96 cycles frame_done pulses once; rd_addr = 5 gives rd_data = 5 one cycle later.
REQ-032 SETTLE = 4, scan_en = 1 -> regadd steps every 5 cycles; frame_done every 160 cycles.
REQ-033 scan_en dropped at entry 10 -> entries 10..31 still captured, one frame_done pulse, then regadd = 0 held in IDLE.
REQ-034 rst low at entry 17 for 1 cycle -> all outputs 0, buffer reads 0 at all 32 addresses, no frame_done until a full new frame.
REQ-035 rd_addr = 7 held while entry 7 is captured with new value 4'hA over old 4'h3 -> rd_data 4'h3 that cycle, 4'hA next.
REQ-036 With REG_SCAN_CHANGE_EN: entry 2 changes 4'h1 -> 4'h9 -> chg_mask = 32'h4; clr_chg on entry 2 capture with another change -> chg_mask = 32'h4; without macro chg_mask stays 0.
